// File: rtl/tc_timer.sv
// Memory-mapped countdown timer: CTRL/PRESET/COUNT registers, IDLE/LOAD/CNT/INT sequencer, level irq.
// Optional feature macro: TC_AUTO_RELOAD_EN enables MODE=01 auto-reload; otherwise every mode is one-shot.
module tc_timer #(
    parameter logic [1:0] RESET_MODE = 2'b00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [3:0]  byteen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

    state_t      state_q;
    logic        en_q;
    logic [1:0]  mode_q;
    logic        im_q;
    logic        pending_q;
    logic [31:0] preset_q;
    logic [31:0] preset_d;
    logic [31:0] count_q;

    logic ctrl_wr;
    logic preset_wr;

    assign ctrl_wr   = we && (addr == 2'd0);
    assign preset_wr = we && (addr == 2'd1);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_preset_lane
            assign preset_d[gi*8 +: 8] = byteen[gi] ? wdata[gi*8 +: 8] : preset_q[gi*8 +: 8];
        end
    endgenerate

    // Bus writes to CTRL are applied after the sequencer so software wins over the INT-state EN clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            en_q      <= 1'b0;
            mode_q    <= RESET_MODE;
            im_q      <= 1'b0;
            pending_q <= 1'b0;
            preset_q  <= 32'd0;
            count_q   <= 32'd0;
        end else begin
            if (ctrl_wr || preset_wr)
                pending_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (en_q)
                        state_q <= LOAD;
                end
                LOAD: begin
                    count_q <= preset_q;
                    state_q <= CNT;
`ifdef TC_AUTO_RELOAD_EN
                    pending_q <= 1'b0;
`endif
                end
                CNT: begin
                    if (!en_q) begin
                        state_q <= IDLE;
                    end else if (count_q > 32'd1) begin
                        count_q <= count_q - 32'd1;
                    end else begin
                        count_q <= 32'd0;
                        state_q <= INT;
                    end
                end
                INT: begin
`ifdef TC_AUTO_RELOAD_EN
                    if (mode_q == 2'b01) begin
                        pending_q <= 1'b1;
                        state_q   <= LOAD;
                    end else
`endif
                    begin
                        pending_q <= 1'b1;
                        en_q      <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (preset_wr)
                preset_q <= preset_d;

            if (ctrl_wr && byteen[0]) begin
                en_q   <= wdata[0];
                mode_q <= wdata[2:1];
                im_q   <= wdata[3];
            end
        end
    end

    always_comb begin
        rdata = 32'd0;
        case (addr)
            2'd0:    rdata = {28'd0, im_q, mode_q, en_q};
            2'd1:    rdata = preset_q;
            2'd2:    rdata = count_q;
            default: rdata = 32'd0;
        endcase
    end

    assign irq = im_q & pending_q;

endmodule
